// File: rtl/z80_wb_pkg.sv
// z80_wb_pkg: shared cycle tags, I/O port map and FSM states for the Wishbone responder
package z80_wb_pkg;
  typedef enum logic [1:0] {
    TGA_MEM  = 2'b00,
    TGA_IO   = 2'b01,
    TGA_INTA = 2'b10,
    TGA_RSVD = 2'b11
  } tga_e;
  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ACK
  } state_e;
  localparam logic [7:0] IO_SCRATCH = 8'h00;
  localparam logic [7:0] IO_VECTOR  = 8'h01;
  localparam logic [7:0] IO_CTRL    = 8'h02;
  function automatic logic [3:0] wait_count(tga_e tga, logic [3:0] mem_wait, logic [3:0] io_wait);
    return tga == TGA_MEM ? mem_wait : io_wait;
  endfunction
endpackage

// File: rtl/z80_wb_ram.sv
// z80_wb_ram: single-port byte RAM with synchronous write and registered read
module z80_wb_ram #(
  parameter int unsigned AW = 12
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [7:0]    wdata,
  output logic [7:0]    rdata
);
  logic [7:0] mem [2**AW];
  // write on request, read data registered every clock from the same address
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end
endmodule

// File: rtl/z80_wb_responder.sv
// z80_wb_responder: Wishbone classic slave with byte RAM, I/O registers and interrupt sources for TV80
module z80_wb_responder
  import z80_wb_pkg::*;
#(
  parameter int unsigned MEM_AW   = 12,
  parameter int unsigned MEM_WAIT = 0,
  parameter int unsigned IO_WAIT  = 2,
  parameter int unsigned NMI_LEN  = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [15:0] wbs_adr_i,
  input  logic [1:0]  wbs_tga_i,
  input  logic [7:0]  wbs_dat_i,
  output logic [7:0]  wbs_dat_o,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  output logic        wbs_ack_o,
  input  logic        ext_irq_i,
  output logic        int_req_o,
  output logic        nmi_req_o
);
  localparam int unsigned AW = MEM_AW > 8 ? MEM_AW : 8;
  state_e state_q, state_d;
  tga_e tga_q;
  logic [AW-1:0] adr_q;
  logic we_q;
  logic [7:0] dat_q;
  logic [3:0] cnt_q;
  logic [7:0] scratch_q, vector_q;
  logic int_q, ext_q;
  logic [3:0] nmi_q;
  logic req, commit, io_wr, ctrl_wr, ram_we, unused_adr;
  logic [7:0] port, ram_rd, io_rd, rd;
  logic [MEM_AW-1:0] ram_addr;
  logic [3:0] load_cnt;

  assign req = wbs_cyc_i & wbs_stb_i;
  assign load_cnt = wait_count(tga_e'(wbs_tga_i), 4'(MEM_WAIT), 4'(IO_WAIT));
  assign unused_adr = ^{1'b0, wbs_adr_i};
  assign commit = state_q == ACK;
  assign port = adr_q[7:0];
  assign ram_we = commit & we_q & (tga_q == TGA_MEM);
  assign io_wr = commit & we_q & (tga_q == TGA_IO);
  assign ctrl_wr = io_wr & (port == IO_CTRL);
  assign ram_addr = state_q == IDLE ? wbs_adr_i[MEM_AW-1:0] : adr_q[MEM_AW-1:0];
  assign io_rd = port == IO_SCRATCH ? scratch_q :
                 port == IO_VECTOR  ? vector_q  :
                 port == IO_CTRL    ? {6'b0, nmi_q != 4'd0, int_q} : 8'hFF;
  assign rd = tga_q == TGA_MEM  ? ram_rd :
              tga_q == TGA_IO   ? io_rd  :
              tga_q == TGA_INTA ? vector_q : 8'hFF;
  assign wbs_ack_o = commit;
  assign wbs_dat_o = commit ? rd : 8'h00;
  assign int_req_o = int_q;
  assign nmi_req_o = nmi_q != 4'd0;

  // next state: accept in IDLE, count wait states (abort on dropped strobe), one-clock ACK
  always_comb begin
    state_d = state_q;
    if (state_q == IDLE) state_d = req ? (load_cnt != 4'd0 ? WAIT : ACK) : IDLE;
    else if (state_q == WAIT) state_d = !req ? IDLE : (cnt_q == 4'd1 ? ACK : WAIT);
    else state_d = IDLE;
  end

  // FSM state register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else state_q <= state_d;
  end

  // capture the accepted request and run the wait-state counter
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      adr_q <= '0;
      tga_q <= TGA_MEM;
      we_q  <= 1'b0;
      dat_q <= 8'h00;
      cnt_q <= 4'd0;
    end else if (state_q == IDLE && req) begin
      adr_q <= wbs_adr_i[AW-1:0];
      tga_q <= tga_e'(wbs_tga_i);
      we_q  <= wbs_we_i;
      dat_q <= wbs_dat_i;
      cnt_q <= load_cnt;
    end else if (state_q == WAIT) begin
      cnt_q <= cnt_q - 4'd1;
    end
  end

  // I/O registers, interrupt pending (set beats clear) and NMI pulse counter
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      scratch_q <= 8'h00;
      vector_q  <= 8'hFF;
      int_q     <= 1'b0;
      ext_q     <= 1'b0;
      nmi_q     <= 4'd0;
    end else begin
      ext_q <= ext_irq_i;
      if (io_wr && port == IO_SCRATCH) scratch_q <= dat_q;
      if (io_wr && port == IO_VECTOR) vector_q <= dat_q;
      if ((ctrl_wr && dat_q[0]) || (ext_irq_i && !ext_q)) int_q <= 1'b1;
      else if (commit && tga_q == TGA_INTA) int_q <= 1'b0;
      if (ctrl_wr && dat_q[1]) nmi_q <= 4'(NMI_LEN);
      else if (nmi_q != 4'd0) nmi_q <= nmi_q - 4'd1;
    end
  end

  z80_wb_ram #(.AW(MEM_AW)) u_ram (
    .clk   (clk_i),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (dat_q),
    .rdata (ram_rd)
  );
endmodule

// File: tb/tb_z80_wb_responder.sv
// tb_z80_wb_responder: directed and randomized checks of the responder against a transaction-level model
module tb_z80_wb_responder;
  localparam int MEM_AW = 12;
  localparam int MEM_WAIT = 0;
  localparam int IO_WAIT = 2;
  localparam int NMI_LEN = 4;
  localparam int SLOW_MEM_WAIT = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [15:0] adr = '0;
  logic [1:0] tga = '0;
  logic [7:0] wdat = '0;
  logic cyc = 1'b0, stb = 1'b0, we = 1'b0, cyc2 = 1'b0, stb2 = 1'b0, ext = 1'b0;
  logic [7:0] dat_o, dat2;
  logic ack, ack2, int_o, nmi_o, int2, nmi2;

  int edges = 0;
  int checks = 0;
  int errors = 0;
  logic [7:0] mem0 [int];
  logic [7:0] mem1 [int];
  logic [7:0] scratch_m = 8'h00, vector_m = 8'hFF;
  bit int_exp = 1'b0;
  int trig = -1000;

  z80_wb_responder #(.MEM_AW(MEM_AW), .MEM_WAIT(MEM_WAIT), .IO_WAIT(IO_WAIT), .NMI_LEN(NMI_LEN)) u_dut (
    .clk_i(clk), .rst_i(rst), .wbs_adr_i(adr), .wbs_tga_i(tga), .wbs_dat_i(wdat), .wbs_dat_o(dat_o),
    .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we), .wbs_ack_o(ack),
    .ext_irq_i(ext), .int_req_o(int_o), .nmi_req_o(nmi_o)
  );

  z80_wb_responder #(.MEM_AW(MEM_AW), .MEM_WAIT(SLOW_MEM_WAIT), .IO_WAIT(IO_WAIT), .NMI_LEN(NMI_LEN)) u_slow (
    .clk_i(clk), .rst_i(rst), .wbs_adr_i(adr), .wbs_tga_i(tga), .wbs_dat_i(wdat), .wbs_dat_o(dat2),
    .wbs_cyc_i(cyc2), .wbs_stb_i(stb2), .wbs_we_i(we), .wbs_ack_o(ack2),
    .ext_irq_i(1'b0), .int_req_o(int2), .nmi_req_o(nmi2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edges <= edges + 1;

  function automatic bit nmi_exp();
    return edges >= trig && edges < trig + NMI_LEN;
  endfunction

  function automatic int idx(logic [15:0] a);
    return int'(a[MEM_AW-1:0]);
  endfunction

  function automatic logic [7:0] io_model(logic [7:0] p);
    if (p == 8'h00) return scratch_m;
    if (p == 8'h01) return vector_m;
    if (p == 8'h02) return {6'b0, nmi_exp(), int_exp};
    return 8'hFF;
  endfunction

  function automatic void commit(bit sel, logic [1:0] t, logic [15:0] a, bit w, logic [7:0] d);
    if (sel) begin
      if (t == 2'b00 && w) mem1[idx(a)] = d;
    end else if (t == 2'b00 && w) mem0[idx(a)] = d;
    else if (t == 2'b01 && w) begin
      if (a[7:0] == 8'h00) scratch_m = d;
      if (a[7:0] == 8'h01) vector_m = d;
      if (a[7:0] == 8'h02 && d[0]) int_exp = 1'b1;
      if (a[7:0] == 8'h02 && d[1]) trig = edges + 1;
    end else if (t == 2'b10) int_exp = 1'b0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    chk("int_req", int_o, int_exp);
    chk("nmi_req", nmi_o, nmi_exp());
  endtask

  task automatic xfer(input bit sel, input logic [1:0] t, input logic [15:0] a, input bit w,
                      input logic [7:0] d, input string tag, input bit ext_at_ack = 1'b0);
    int lat, wt;
    bit got, known;
    logic [7:0] exp;
    adr = a; tga = t; we = w; wdat = d;
    if (sel) begin cyc2 = 1'b1; stb2 = 1'b1; end
    else begin cyc = 1'b1; stb = 1'b1; end
    wt = (t == 2'b00) ? (sel ? SLOW_MEM_WAIT : MEM_WAIT) : IO_WAIT;
    lat = 0;
    got = 1'b0;
    while (!got && lat < 20) begin
      tick();
      lat++;
      got = sel ? ack2 : ack;
    end
    chk({tag, "_ack"}, 32'(got), 32'd1);
    chk({tag, "_lat"}, lat, wt + 1);
    known = 1'b1;
    exp = 8'hFF;
    if (t == 2'b00) begin
      known = sel ? mem1.exists(idx(a)) : mem0.exists(idx(a));
      if (known) exp = sel ? mem1[idx(a)] : mem0[idx(a)];
    end else if (t == 2'b01) exp = io_model(a[7:0]);
    else if (t == 2'b10) exp = vector_m;
    if (got && known && (!w || t == 2'b10)) chk({tag, "_dat"}, sel ? dat2 : dat_o, exp);
    if (got) commit(sel, t, a, w, d);
    if (ext_at_ack) begin ext = 1'b1; int_exp = 1'b1; end
    cyc = 1'b0; stb = 1'b0; cyc2 = 1'b0; stb2 = 1'b0;
    tick();
    chk({tag, "_ackoff"}, 32'(sel ? ack2 : ack), 32'd0);
    chk({tag, "_dat0"}, sel ? dat2 : dat_o, 8'h00);
  endtask

  initial begin
    logic [15:0] a;
    logic [7:0] p;
    int k;
    repeat (2) @(negedge clk);
    chk("rst_ack", ack, 0);
    chk("rst_dat", dat_o, 8'h00);
    chk("rst_int", int_o, 0);
    chk("rst_nmi", nmi_o, 0);
    chk("rst_ack_slow", ack2, 0);
    rst = 1'b0;
    tick();
    xfer(0, 2'b00, 16'h0123, 1, 8'hA5, "mem_wr");
    xfer(0, 2'b00, 16'h0123, 0, 8'h00, "mem_rd");
    xfer(0, 2'b00, 16'h1123, 0, 8'h00, "mem_alias");
    xfer(0, 2'b01, 16'h0001, 0, 8'h00, "io_vec_rst");
    xfer(0, 2'b01, 16'h007F, 0, 8'h00, "io_unmapped");
    xfer(0, 2'b01, 16'h0000, 0, 8'h00, "io_scr_rst");
    xfer(0, 2'b11, 16'h0055, 0, 8'h00, "rsvd_rd");
    xfer(0, 2'b01, 16'h0002, 1, 8'h01, "int_set");
    xfer(0, 2'b01, 16'h0001, 1, 8'h40, "vec_wr");
    xfer(0, 2'b10, 16'h0000, 0, 8'h00, "inta");
    xfer(0, 2'b01, 16'h0002, 1, 8'h01, "int_set2");
    xfer(0, 2'b10, 16'h0000, 0, 8'h00, "inta_ext", 1'b1);
    xfer(0, 2'b10, 16'h0000, 1, 8'h00, "inta_clr");
    ext = 1'b0;
    tick();
    xfer(0, 2'b01, 16'h0002, 1, 8'h02, "nmi_start");
    repeat (6) tick();
    xfer(0, 2'b01, 16'h0002, 1, 8'h02, "nmi_first");
    xfer(0, 2'b01, 16'h0002, 1, 8'h02, "nmi_retrig");
    xfer(0, 2'b01, 16'h0002, 0, 8'h00, "ctrl_rd");
    repeat (8) tick();
    xfer(0, 2'b01, 16'h0000, 1, 8'h33, "scr_wr");
    adr = 16'h0000; tga = 2'b01; we = 1'b1; wdat = 8'h99; cyc = 1'b1; stb = 1'b1;
    tick();
    chk("abort_io_ack_a", ack, 0);
    cyc = 1'b0; stb = 1'b0;
    repeat (3) begin
      tick();
      chk("abort_io_ack_b", ack, 0);
    end
    xfer(0, 2'b01, 16'h0000, 0, 8'h00, "scr_keep");
    xfer(1, 2'b00, 16'h0200, 1, 8'h11, "slow_wr");
    adr = 16'h0200; tga = 2'b00; we = 1'b1; wdat = 8'h5A; cyc2 = 1'b1; stb2 = 1'b1;
    tick();
    chk("abort_mem_ack_a", ack2, 0);
    stb2 = 1'b0;
    repeat (3) begin
      tick();
      chk("abort_mem_ack_b", ack2, 0);
    end
    cyc2 = 1'b0;
    xfer(1, 2'b00, 16'h0200, 0, 8'h00, "slow_keep");
    repeat (80) begin
      repeat ($urandom_range(0, 2)) tick();
      k = $urandom_range(0, 7);
      a = {4'($urandom_range(0, 15)), 8'h00, 4'($urandom_range(0, 15))};
      p = ($urandom_range(0, 3) == 3) ? 8'($urandom) : 8'($urandom_range(0, 2));
      if (k == 0) xfer(0, 2'b00, a, 1, 8'($urandom), "r_mem_wr");
      else if (k <= 2) xfer(0, 2'b00, a, !mem0.exists(idx(a)), 8'($urandom), "r_mem");
      else if (k == 3) xfer(0, 2'b01, {8'($urandom), p}, 1, 8'($urandom), "r_io_wr");
      else if (k == 4) xfer(0, 2'b01, {8'($urandom), p}, 0, 8'h00, "r_io_rd");
      else if (k == 5) xfer(0, 2'b10, 16'($urandom), 1'($urandom), 8'($urandom), "r_inta");
      else if (k == 6) xfer(0, 2'b11, 16'($urandom), 1'($urandom), 8'($urandom), "r_rsvd");
      else begin
        ext = 1'b1;
        int_exp = 1'b1;
        tick();
        ext = 1'b0;
        tick();
      end
    end
    xfer(0, 2'b01, 16'h0002, 1, 8'h03, "ctrl_both");
    adr = 16'h0000; tga = 2'b01; we = 1'b1; wdat = 8'h77; cyc = 1'b1; stb = 1'b1;
    tick();
    rst = 1'b1;
    int_exp = 1'b0; trig = -1000; scratch_m = 8'h00; vector_m = 8'hFF;
    #1;
    chk("rstw_ack", ack, 0);
    chk("rstw_dat", dat_o, 8'h00);
    chk("rstw_int", int_o, 0);
    chk("rstw_nmi", nmi_o, 0);
    cyc = 1'b0; stb = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    xfer(0, 2'b01, 16'h0000, 0, 8'h00, "post_rst_scr");
    xfer(0, 2'b01, 16'h0001, 0, 8'h00, "post_rst_vec");
    xfer(0, 2'b00, 16'h0123, 0, 8'h00, "post_rst_mem");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/z80_wb_responder.md
# z80_wb_responder

Wishbone classic slave that serves the 8-bit TV80 Wishbone master: the responder end of the same bus the CPU wrapper drives. Decodes the cycle tag into memory, I/O and interrupt-acknowledge accesses, inserts programmable wait states and holds a byte RAM plus a small I/O register file. Its int_req_o/nmi_req_o feed the CPU's interrupt inputs, so one instance with the CPU forms a self-contained system for simulation and bring-up.

## Interface
- MEM_AW, 12: RAM address width; RAM is 2**MEM_AW bytes.
- MEM_WAIT, 0: wait states for memory cycles (0..15).
- IO_WAIT, 2: wait states for I/O and interrupt-acknowledge cycles (0..15).
- NMI_LEN, 4: nmi_req_o pulse length in clocks (1..15).
- clk_i  in  1  system clock.
- rst_i  in  1  asynchronous, active-high reset.
- wbs_adr_i  in  16  byte address; I/O uses [7:0].
- wbs_tga_i  in  2  cycle tag: 00 memory, 01 I/O, 10 interrupt ack, 11 reserved.
- wbs_dat_i  in  8  write data.
- wbs_dat_o  out  8  read data, valid while wbs_ack_o is high.
- wbs_cyc_i, wbs_stb_i, wbs_we_i  in  1 each  classic Wishbone controls.
- wbs_ack_o  out  1  transfer acknowledge, registered.
- ext_irq_i  in  1  external interrupt source, rising-edge sensitive, synchronous to clk_i.
- int_req_o  out  1  maskable interrupt request level to CPU.
- nmi_req_o  out  1  NMI pulse to CPU.

## Operation
- FSM states: IDLE, WAIT, ACK.
- IDLE: cyc&stb sampled high -> latch adr/tga/we/dat; load wait counter with MEM_WAIT (tga 00) or IO_WAIT (else); go to WAIT if count>0, else ACK.
- WAIT: decrement each clock; at 1 -> ACK.
- ACK: wbs_ack_o=1 for exactly one clock; read data driven; write committed on this edge; next state IDLE.
- Abort: cyc or stb low in WAIT -> IDLE, no ack, no write commit, no side effects.
- Back-to-back: stb still high in the clock after ACK counts as a new transfer.
- Memory (00): RAM index = adr[MEM_AW-1:0]; upper bits ignored (aliasing/wrap).
- I/O (01), adr[7:0]: 0x00 scratch reg R/W; 0x01 IM2 vector reg R/W; 0x02 control: write bit0=1 sets int pending, bit1=1 starts NMI pulse; read = {6'b0, nmi_active, int_pending}. Other ports: read 0xFF, writes ignored.
- Interrupt ack (10): dat_o = vector reg; clears int pending on the ACK edge. wbs_we_i ignored.
- Reserved (11): ack normally with IO_WAIT, read 0xFF, writes ignored.
- int_req_o = int pending. Set by control write or ext_irq_i rising edge (previous-sample register); cleared only by intack. Set and clear on the same edge -> set wins.
- NMI: counter loads NMI_LEN; nmi_req_o high while nonzero; retrigger during pulse reloads.

## Timing
- Reset values: wbs_ack_o 0, wbs_dat_o 0x00, int_req_o 0, nmi_req_o 0, scratch 0x00, vector 0xFF, FSM IDLE, ext_irq edge register 0. RAM contents not reset.
- Latency: stb sampled at edge N -> ack high during cycle N+1+WAIT.
- wbs_dat_o returns to 0x00 the clock after ack.
- NMI: control write acked at edge N -> nmi_req_o high for cycles N+1..N+NMI_LEN.
- ext_irq_i rising at edge N -> int_req_o high from cycle N+1.
- Reset mid-transfer: immediate return to IDLE, ack low, pending write dropped.

## Structure
- Package z80_wb_pkg: tga enum (TGA_MEM, TGA_IO, TGA_INTA, TGA_RSVD), I/O port constants (IO_SCRATCH, IO_VECTOR, IO_CTRL), FSM state enum.
- Sub-module z80_wb_ram: single-port byte RAM, synchronous write, read data registered into the ACK cycle.

## Test plan
- Memory write 0xA5 to 0x0123, read back; MEM_WAIT=0: ack one clock after stb each, read 0xA5; read 0x1123 (MEM_AW=12) also returns 0xA5.
- I/O read port 0x01 after reset with IO_WAIT=2 -> ack 3 clocks after stb, dat 0xFF; read port 0x7F -> 0xFF.
- Write 0x01 to port 0x02 -> int_req_o high next clock; intack cycle with vector 0x40 -> dat 0x40, int_req_o low the clock after ack.
- ext_irq_i rising on the same edge as intack ack -> int_req_o stays high.
- Write 0x02 to port 0x02 -> nmi_req_o high exactly 4 clocks; rewrite in clock 2 -> 4 more clocks from the rewrite.
- Drop stb during WAIT of a memory write 0x5A -> no ack, later read returns old value; assert rst_i mid-wait -> all outputs at reset values.
